des_key_schedule_gen: RTL and testbench
=======================================

// Module: des_key_schedule_gen
// PURPOSE
//  Sequential DES/TDEA subkey generator. Holds a bundle of NUM_KEYS 64-bit keys and, on request,
//  runs PC-1, the 16-round rotation schedule and PC-2 on one selected key. It streams the sixteen
//  48-bit subkeys over a valid/ready interface, in encrypt order (K1..K16) or decrypt order (K16..K1).
//  It feeds the round datapath and supports TDEA keying options 1-3 (EDE).
// PARAMETERS
//  NUM_KEYS   3    key slots held (1..4); KEY_SEL width = max(1,$clog2(NUM_KEYS))
//  SEL_W      2    width of KEY_SEL (set consistent with NUM_KEYS)
// PORTS
//  CLK            in   1            clock, all state on rising edge
//  RESET          in   1            synchronous, active-high
//  LOAD           in   1            latch KEY_IN into all slots (IDLE only)
//  KEY_IN         in   64*NUM_KEYS  slot s = KEY_IN[64*s+63:64*s]; [63] = DES bit 1 (FIPS 46-3)
//  START          in   1            begin schedule for slot KEY_SEL (IDLE only)
//  KEY_SEL        in   SEL_W        slot index
//  MODE           in   1            0 = encrypt order K1..K16, 1 = decrypt order K16..K1
//  SUBKEY         out  48           current subkey; [47] = PC-2 output bit 1
//  ROUND_IDX      out  4            DES index of SUBKEY minus 1 (K1 -> 0 ... K16 -> 15)
//  SUBKEY_VALID   out  1            SUBKEY/ROUND_IDX valid
//  SUBKEY_READY   in   1            consumer accepts on VALID & READY
//  BUSY           out  1            high in PC1 and ROUND states
//  DONE           out  1            one-cycle pulse after 16th handshake
//  ERR            out  1            sticky error; cleared by next accepted START or RESET
// BEHAVIOUR
//  Reset: FSM=IDLE; key slots, C/D regs, SUBKEY, ROUND_IDX cleared to 0; VALID, BUSY, DONE, ERR = 0.
//  States:
//   IDLE  -> PC1 on accepted START.
//   PC1   -> ROUND after 1 cycle. C,D <= PC-1(slot); n <= 1.
//   ROUND -> IDLE after 16th handshake.
//  LOAD in IDLE: all slots <= KEY_IN next edge. LOAD outside IDLE: ignored.
//  START accepted only in IDLE with LOAD low. LOAD has priority; same-cycle START is dropped.
//  START with KEY_SEL >= NUM_KEYS: not accepted; ERR <= 1; stays IDLE.
//  START outside IDLE: ignored, no effect on ERR.
//  MODE, KEY_SEL sampled only at accepted START; later changes have no effect until next run.
//  Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (28-bit rotations of C and D).
//  Encrypt, output n: C,D <= rotl(C,D,S[n]); SUBKEY <= PC-2(rotated); ROUND_IDX <= n-1.
//  Decrypt, output 1: no rotation, SUBKEY = PC-2(C0,D0) = K16.
//  Decrypt, output n>=2: C,D <= rotr(C,D,S[18-n]); ROUND_IDX <= 16-n.
//  Latency: START sampled at edge t -> first SUBKEY_VALID high after edge t+2.
//  VALID rises entering ROUND and stays high until the 16th handshake.
//  SUBKEY and ROUND_IDX hold stable while VALID & !READY.
//  Each handshake registers the next subkey on the same edge: 1 subkey/cycle under READY=1,
//  16 handshakes total. Run takes 18 cycles from START to DONE with READY tied high.
//  16th handshake: VALID <= 0, DONE <= 1 for one cycle, FSM -> IDLE. SUBKEY keeps last value.
//  RESET mid-run aborts immediately with reset values; no DONE pulse.
//  C,D after 16 encrypt rotations equal C0,D0 (28 total shifts); no correction needed.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//   At START, each byte of the selected slot must have odd parity.
//   On any failing byte: START not accepted, ERR <= 1, stays IDLE.
//  PARITY_CHECK_EN undefined:
//   Parity bits (DES bits 8,16,...,64) are ignored; ERR is set only by bad KEY_SEL.
// TESTING
//  1 LOAD slot0=133457799BBCDFF1; START MODE=0 SEL=0; READY=1
//    -> K1=1B02EFFC7072 IDX0, K16=CB3D8B0E17F5 IDX15.
//    -> DONE 18 cycles after START; BUSY falls with DONE.
//  2 Same key, MODE=1 -> first SUBKEY=CB3D8B0E17F5 (IDX15), last=1B02EFFC7072 (IDX0);
//    all 16 equal the encrypt set reversed.
//  3 READY toggled 1,0,0,1,... -> SUBKEY/IDX stable during stalls;
//    exactly 16 handshakes; no duplicate or skipped index.
//  4 Slot1=slot2=key from scenario 1, slot0=0; START SEL=2 -> K1=1B02EFFC7072.
//    START SEL=3 (NUM_KEYS=3) -> ERR=1, BUSY=0.
//  5 RESET after 5th handshake -> next cycle VALID=0, BUSY=0, SUBKEY=0, no DONE.
//    START/LOAD during run are ignored.
//  6 PARITY_CHECK_EN: slot0=0000000000000000, START -> ERR=1, no VALID.
//    Without the macro -> normal run, ERR=0.

Source files
------------

// File: rtl/des_key_schedule_gen.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule_gen
// Brief    : Sequential DES/TDEA subkey generator (PC-1, rotations, PC-2)
//            streaming K1..K16 or K16..K1 over valid/ready.
//            Optional build macro: PARITY_CHECK_EN (odd byte parity at START).
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule_gen #(
  parameter int NUM_KEYS = 3,
  parameter int SEL_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [64*NUM_KEYS-1:0]  key_in,
  input  logic                    start,
  input  logic [SEL_W-1:0]        key_sel,
  input  logic                    mode,
  output logic [47:0]             subkey,
  output logic [3:0]              round_idx,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // Tables hold DES bit numbers (1 = MSB), first output bit in the top byte.
  localparam logic [8*56-1:0] c_pc1 = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam logic [8*48-1:0] c_pc2 = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  localparam logic [31:0] c_num_keys = NUM_KEYS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PC1   = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    int          b;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      b = int'(c_pc1[8*(55-i) +: 8]);
      r[55-i] = k[64-b];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    int          b;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      b = int'(c_pc2[8*(47-i) +: 8]);
      r[47-i] = cd[56-b];
    end
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic shift_two(input logic [4:0] n);
    return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t            r_state;
  state_t            w_state_nx;
  logic [63:0]       r_slot [NUM_KEYS];
  logic [SEL_W-1:0]  r_sel;
  logic              r_mode;
  logic [27:0]       r_c;
  logic [27:0]       r_d;
  logic [4:0]        r_n;
  logic [47:0]       r_subkey;
  logic [3:0]        r_idx;
  logic              r_valid;
  logic              r_done;
  logic              r_err;

  logic [63:0]       w_sel_key;
  logic              w_sel_ok;
  logic              w_par_ok;
  logic [63:0]       w_run_key;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_two;
  logic [27:0]       w_c_nx;
  logic [27:0]       w_d_nx;
  logic [3:0]        w_idx_nx;
  logic [47:0]       w_subkey_nx;
  logic              w_busy;
  logic              w_last_hs;

  always_comb begin
    w_sel_key = '0;
    w_sel_ok  = 1'b0;
    w_run_key = '0;
    for (int s = 0; s < NUM_KEYS; s++) begin
      if (key_sel == SEL_W'(s)) begin
        w_sel_key = r_slot[s];
        w_sel_ok  = 1'b1;
      end
      if (r_sel == SEL_W'(s)) begin
        w_run_key = r_slot[s];
      end
    end
    if (32'(key_sel) >= c_num_keys) begin
      w_sel_ok = 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  always_comb begin
    w_par_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^w_sel_key[8*b +: 8])) begin
        w_par_ok = 1'b0;
      end
    end
  end
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_start_ok  = (r_state == ST_IDLE) && start && !load && w_sel_ok && w_par_ok;
  assign w_start_bad = (r_state == ST_IDLE) && start && !load && !(w_sel_ok && w_par_ok);
  assign w_last_hs   = r_valid && subkey_ready && (r_n == 5'd17);

  // Decrypt walks the schedule backwards: K16 comes straight from C0/D0.
  always_comb begin
    w_two    = 1'b0;
    w_c_nx   = r_c;
    w_d_nx   = r_d;
    w_idx_nx = 4'd15;
    if (!r_mode) begin
      w_two    = shift_two(r_n);
      w_c_nx   = rotl28(r_c, w_two);
      w_d_nx   = rotl28(r_d, w_two);
      w_idx_nx = 4'(r_n - 5'd1);
    end else if (r_n != 5'd1) begin
      w_two    = shift_two(5'(5'd18 - r_n));
      w_c_nx   = rotr28(r_c, w_two);
      w_d_nx   = rotr28(r_d, w_two);
      w_idx_nx = 4'(5'd16 - r_n);
    end
    w_subkey_nx = pc2({w_c_nx, w_d_nx});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_busy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nx = ST_PC1;
        end
      end
      ST_PC1: begin
        w_busy     = 1'b1;
        w_state_nx = ST_ROUND;
      end
      ST_ROUND: begin
        w_busy = 1'b1;
        if (w_last_hs) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_KEYS; s++) begin
        r_slot[s] <= '0;
      end
      r_sel    <= '0;
      r_mode   <= 1'b0;
      r_c      <= '0;
      r_d      <= '0;
      r_n      <= '0;
      r_subkey <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            for (int s = 0; s < NUM_KEYS; s++) begin
              r_slot[s] <= key_in[64*s +: 64];
            end
          end
          if (w_start_ok) begin
            r_sel  <= key_sel;
            r_mode <= mode;
            r_err  <= 1'b0;
          end else if (w_start_bad) begin
            r_err <= 1'b1;
          end
        end
        ST_PC1: begin
          {r_c, r_d} <= pc1(w_run_key);
          r_n        <= 5'd1;
        end
        ST_ROUND: begin
          if (w_last_hs) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else if (!r_valid || subkey_ready) begin
            r_c      <= w_c_nx;
            r_d      <= w_d_nx;
            r_subkey <= w_subkey_nx;
            r_idx    <= w_idx_nx;
            r_valid  <= 1'b1;
            r_n      <= r_n + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign subkey       = r_subkey;
  assign round_idx    = r_idx;
  assign subkey_valid = r_valid;
  assign busy         = w_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule_gen
// Brief    : Directed self-checking bench for des_key_schedule_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule_gen;

  localparam int          NUM_KEYS = 3;
  localparam int          SEL_W    = 2;
  localparam logic [63:0] C_KEY    = 64'h133457799BBCDFF1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   load;
  logic [64*NUM_KEYS-1:0] key_in;
  logic                   start;
  logic [SEL_W-1:0]       key_sel;
  logic                   mode;
  logic [47:0]            subkey;
  logic [3:0]             round_idx;
  logic                   subkey_valid;
  logic                   subkey_ready;
  logic                   busy;
  logic                   done;
  logic                   err;

  des_key_schedule_gen #(.NUM_KEYS(NUM_KEYS), .SEL_W(SEL_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .key_in       (key_in),
    .start        (start),
    .key_sel      (key_sel),
    .mode         (mode),
    .subkey       (subkey),
    .round_idx    (round_idx),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  logic [47:0] c_k [16];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [47:0] hs_key [16];
  logic [3:0]  hs_idx [16];
  int          hs_cnt;
  int          first_v;
  int          done_cyc;
  int          viol;
  logic        busy0;
  logic        busy_at_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one schedule and capture every handshake; ready optionally follows 1,0,0 repeating.
  task automatic run(input logic mode_i, input logic [SEL_W-1:0] sel_i, input bit stall);
    bit          stalled;
    bit          got_done;
    bit          r;
    logic [47:0] pk;
    logic [3:0]  pi;
    int          rc;
    hs_cnt = 0; first_v = -1; done_cyc = -1; viol = 0;
    busy0 = 1'b0; busy_at_done = 1'b1;
    stalled = 1'b0; got_done = 1'b0; rc = 0; pk = '0; pi = '0;
    start = 1'b1; mode = mode_i; key_sel = sel_i;
    tick();
    start = 1'b0; mode = ~mode_i; key_sel = '0;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      if (stalled && (subkey !== pk || round_idx !== pi)) viol++;
      if (cyc == 0) busy0 = busy;
      if (done) begin
        got_done     = 1'b1;
        done_cyc     = cyc;
        busy_at_done = busy;
      end else begin
        if (subkey_valid && first_v < 0) first_v = cyc;
        r  = stall ? (rc % 3 == 0) : 1'b1;
        rc++;
        subkey_ready = r;
        stalled = subkey_valid && !r;
        pk = subkey;
        pi = round_idx;
        if (subkey_valid && r) begin
          if (hs_cnt < 16) begin
            hs_key[hs_cnt] = subkey;
            hs_idx[hs_cnt] = round_idx;
          end
          hs_cnt++;
        end
        tick();
      end
    end
    subkey_ready = 1'b1;
    check("run_timeout", 64'(got_done), 64'd1);
  endtask

  task automatic verify(input string tag, input bit dec, input bit zero_key, input bit timing);
    int e;
    check({tag, "_hs_count"}, 64'(hs_cnt), 64'd16);
    check({tag, "_first_valid_cyc"}, 64'(first_v), 64'd2);
    check({tag, "_busy_in_pc1"}, 64'(busy0), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, "_stall_stability"}, 64'(viol), 64'd0);
    if (timing) check({tag, "_done_cyc"}, 64'(done_cyc), 64'd18);
    for (int i = 0; i < 16; i++) begin
      e = dec ? 15 - i : i;
      check($sformatf("%s_key%0d", tag, i), 64'(hs_key[i]), zero_key ? 64'd0 : 64'(c_k[e]));
      check($sformatf("%s_idx%0d", tag, i), 64'(hs_idx[i]), 64'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int vseen;
    c_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
            48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
            48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
            48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    reset = 1'b1; load = 1'b0; start = 1'b0; key_sel = '0; mode = 1'b0;
    subkey_ready = 1'b1; key_in = '0;
    repeat (3) tick();
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_idx", 64'(round_idx), 64'd0);
    reset = 1'b0;
    tick();

    // Encrypt, decrypt and stalled encrypt on slot 0
    key_in = {64'h0, 64'h0, C_KEY};
    load = 1'b1; tick(); load = 1'b0;
    run(1'b0, 2'd0, 1'b0);
    verify("enc", 1'b0, 1'b0, 1'b1);
    check("enc_err", 64'(err), 64'd0);
    run(1'b1, 2'd0, 1'b0);
    verify("dec", 1'b1, 1'b0, 1'b1);
    run(1'b0, 2'd0, 1'b1);
    verify("stall", 1'b0, 1'b0, 1'b0);

    // LOAD wins over a same-cycle START
    key_in = {C_KEY, C_KEY, 64'h0};
    load = 1'b1; start = 1'b1; key_sel = 2'd2;
    tick();
    load = 1'b0; start = 1'b0;
    check("load_prio_busy", 64'(busy), 64'd0);
    tick();
    check("load_prio_valid", 64'(subkey_valid), 64'd0);

    // Slot selection and out-of-range select
    run(1'b0, 2'd2, 1'b0);
    verify("sel2", 1'b0, 1'b0, 1'b1);
    start = 1'b1; key_sel = 2'd3;
    tick();
    start = 1'b0;
    check("badsel_err", 64'(err), 64'd1);
    check("badsel_busy", 64'(busy), 64'd0);
    tick(); tick();
    check("badsel_valid", 64'(subkey_valid), 64'd0);
    run(1'b0, 2'd1, 1'b0);
    check("err_cleared", 64'(err), 64'd0);
    check("sel1_key0", 64'(hs_key[0]), 64'(c_k[0]));

    // Mid-run LOAD/START ignored; RESET after 5th handshake aborts
    start = 1'b1; mode = 1'b0; key_sel = 2'd1;
    tick();
    start = 1'b0;
    hs = 0;
    for (int cyc = 0; cyc < 40 && hs < 5; cyc++) begin
      load   = (cyc < 3);
      start  = (cyc < 3);
      mode   = 1'b1;
      key_in = '0;
      if (subkey_valid) begin
        check($sformatf("abort_key%0d", hs), 64'(subkey), 64'(c_k[hs]));
        hs++;
      end
      tick();
    end
    load = 1'b0; start = 1'b0; mode = 1'b0;
    check("abort_hs5", 64'(hs), 64'd5);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("abort_valid", 64'(subkey_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_subkey", 64'(subkey), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();
    check("abort_no_done", 64'(done), 64'd0);

    // All-zero key: even parity in every byte
    key_in = '0;
    load = 1'b1; tick(); load = 1'b0;
`ifdef PARITY_CHECK_EN
    start = 1'b1; key_sel = 2'd0;
    tick();
    start = 1'b0;
    check("parity_err", 64'(err), 64'd1);
    check("parity_busy", 64'(busy), 64'd0);
    vseen = 0;
    for (int i = 0; i < 5; i++) begin
      if (subkey_valid) vseen++;
      tick();
    end
    check("parity_no_valid", 64'(vseen), 64'd0);
`else
    vseen = 0;
    run(1'b0, 2'd0, 1'b0);
    verify("zero", 1'b0, 1'b1, 1'b1);
    check("zero_err", 64'(err), 64'(vseen));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
